fifo_flow_ctrl: RTL and testbench
=================================

// Module: fifo_flow_ctrl
// PURPOSE
//  Parametrised synchronous FIFO with internally managed read/write pointers.
//  Replaces the externally addressed memory_6x8 scheme: callers no longer drive pointers.
//  Adds occupancy count, programmable almost-full/almost-empty thresholds and sticky
//  overflow/underflow errors, so PCIe switch lanes can apply back-pressure.
//  Sits between the lane input stage and the switch arbiter, one instance per VC.
// PARAMETERS
//  ADDR_SIZE  3  pointer width; DEPTH = 2**ADDR_SIZE entries
//  DATA_SIZE  8  word width in bits
// PORTS
//  clk               input   1              system clock, all logic on rising edge
//  reset             input   1              asynchronous, active-low reset
//  write             input   1              push request, data_in sampled same edge
//  read              input   1              pop request
//  data_in           input   DATA_SIZE      push data
//  almost_full_thr   input   ADDR_SIZE+1    almost_full asserted when count >= thr
//  almost_empty_thr  input   ADDR_SIZE+1    almost_empty asserted when count <= thr
//  err_clr           input   1              synchronous clear of sticky error flags
//  data_out          output  DATA_SIZE      registered pop data
//  valid_out         output  1              data_out holds a newly popped word this cycle
//  full              output  1              count == DEPTH
//  empty             output  1              count == 0
//  almost_full       output  1              count >= almost_full_thr
//  almost_empty      output  1              count <= almost_empty_thr
//  fifo_count        output  ADDR_SIZE+1    current occupancy, 0..DEPTH
//  overflow          output  1              sticky: write rejected because full
//  underflow         output  1              sticky: read rejected because empty
// BEHAVIOUR
//  - Reset (reset==0, async): wr_ptr=rd_ptr=0, count=0, data_out=0, valid_out=0,
//    overflow=underflow=0; full=0, empty=1; almost flags follow count vs thresholds.
//    Memory contents are not cleared. Reset mid-operation discards all queued data.
//  - Accepted write: write && (!full || read). Stores data_in at wr_ptr; wr_ptr+1 mod DEPTH.
//  - Accepted read: read && !empty. data_out <= mem[rd_ptr] on that edge; valid_out=1
//    for the following cycle only (1-cycle latency); rd_ptr+1 mod DEPTH.
//  - No accepted read: data_out holds its last value, valid_out=0.
//  - Count: +1 write only, -1 read only, unchanged when both or neither are accepted.
//  - Full and read+write same cycle: both accepted, count stays DEPTH, no overflow.
//  - Empty and read+write same cycle: write accepted, read rejected (no bypass),
//    underflow set, count becomes 1.
//  - Write while full without read: ignored, contents/pointers unchanged, overflow set.
//  - Read while empty: ignored, data_out unchanged, valid_out=0, underflow set.
//  - Pointers wrap naturally at DEPTH-1 -> 0; full/empty are derived from count, never
//    from pointer equality.
//  - Status flags (full, empty, almost_*, fifo_count) are combinational from the count
//    register and threshold inputs; they reflect the post-edge state.
//  - err_clr clears overflow/underflow; if an error event occurs in the same cycle,
//    the set wins.
//  - Thresholds may change at any time; flags update combinationally.
// TESTING
//  1. Reset held 0, then released -> empty=1, full=0, fifo_count=0, data_out=0, valid_out=0.
//  2. Push 0x01..0x08 (DEPTH=8), then pop 8 -> full=1 after 8th push; pops return
//     0x01..0x08 in order, valid_out one cycle after each read, empty=1 at end.
//  3. Full, write 0xAA without read -> overflow=1, count=8, next pops unchanged;
//     pulse err_clr -> overflow=0.
//  4. Full, read+write 0x55 same cycle -> data_out=oldest word, count stays 8, no
//     overflow; 0x55 appears as 8th subsequent pop.
//  5. Empty, read+write 0x3C -> underflow=1, count=1, valid_out=0; next read gives 0x3C.
//  6. thr_af=6, thr_ae=1: push 6 -> almost_full=1 at count 6; pop to 1 -> almost_empty=1;
//     20 push/pop pairs across wrap -> data order intact; reset mid-stream -> count=0.

Source files
------------

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with internal pointers, occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_flow_ctrl #(
  parameter int ADDR_SIZE = 3,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE:0]   almost_full_thr,
  input  logic [ADDR_SIZE:0]   almost_empty_thr,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   fifo_count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                 DEPTH    = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C  = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] CNT_ZERO = (ADDR_SIZE+1)'(1'b0);
  localparam logic [ADDR_SIZE:0] CNT_ONE  = (ADDR_SIZE+1)'(1'b1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1'b1);

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_r;
  logic [ADDR_SIZE-1:0] rd_ptr_r;
  logic [ADDR_SIZE:0]   count_r;
  logic [ADDR_SIZE:0]   count_nxt_s;
  logic [DATA_SIZE-1:0] data_out_r;
  logic                 valid_r;
  logic                 overflow_r;
  logic                 underflow_r;
  logic                 ovf_nxt_s;
  logic                 udf_nxt_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 wr_acc_s;
  logic                 rd_acc_s;
  logic                 ovf_evt_s;
  logic                 udf_evt_s;

  // Full/empty come from the count, so pointer equality is never ambiguous.
  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == CNT_ZERO);
  assign wr_acc_s  = write && (!full_s || read);
  assign rd_acc_s  = read && !empty_s;
  assign ovf_evt_s = write && full_s && !read;
  assign udf_evt_s = read && empty_s;

  // Next occupancy and sticky-error values; an error event beats err_clr.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    ovf_nxt_s = overflow_r;
    if (ovf_evt_s) begin
      ovf_nxt_s = 1'b1;
    end else if (err_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = overflow_r;
    end

    udf_nxt_s = underflow_r;
    if (udf_evt_s) begin
      udf_nxt_s = 1'b1;
    end else if (err_clr) begin
      udf_nxt_s = 1'b0;
    end else begin
      udf_nxt_s = underflow_r;
    end
  end

  // Storage array, intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, count, pop data and error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {ADDR_SIZE{1'b0}};
      rd_ptr_r    <= {ADDR_SIZE{1'b0}};
      count_r     <= CNT_ZERO;
      data_out_r  <= {DATA_SIZE{1'b0}};
      valid_r     <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        data_out_r <= mem_r[rd_ptr_r];
        valid_r    <= 1'b1;
      end else begin
        valid_r    <= 1'b0;
      end
      count_r     <= count_nxt_s;
      overflow_r  <= ovf_nxt_s;
      underflow_r <= udf_nxt_s;
    end
  end

  assign data_out     = data_out_r;
  assign valid_out    = valid_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= almost_full_thr);
  assign almost_empty = (count_r <= almost_empty_thr);
  assign fifo_count   = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed plus randomized checks of fifo_flow_ctrl against a queue-based
// reference model of the FIFO's occupancy, ordering and error rules.
module tb_fifo_flow_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          write;
  logic          read;
  logic [DW-1:0] data_in;
  logic [AW:0]   almost_full_thr;
  logic [AW:0]   almost_empty_thr;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          underflow;

  fifo_flow_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .write            (write),
    .read             (read),
    .data_in          (data_in),
    .almost_full_thr  (almost_full_thr),
    .almost_empty_thr (almost_empty_thr),
    .err_clr          (err_clr),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .full             (full),
    .empty            (empty),
    .almost_full      (almost_full),
    .almost_empty     (almost_empty),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q_m [$];
  logic [DW-1:0] exp_dout_m;
  logic          exp_valid_m;
  logic          exp_ovf_m;
  logic          exp_udf_m;

  int n_checks;
  int n_pass;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q_m.size();
    check_val({tag, ":data_out"},  32'(data_out), 32'(exp_dout_m));
    check_val({tag, ":valid_out"}, 32'(valid_out), 32'(exp_valid_m));
    check_val({tag, ":count"},     32'(fifo_count), sz);
    check_val({tag, ":full"},      32'(full), 32'(sz == DEPTH));
    check_val({tag, ":empty"},     32'(empty), 32'(sz == 0));
    check_val({tag, ":afull"},     32'(almost_full), 32'(sz >= int'(almost_full_thr)));
    check_val({tag, ":aempty"},    32'(almost_empty), 32'(sz <= int'(almost_empty_thr)));
    check_val({tag, ":overflow"},  32'(overflow), 32'(exp_ovf_m));
    check_val({tag, ":underflow"}, 32'(underflow), 32'(exp_udf_m));
  endtask

  // One clock: drive at negedge, update the model at posedge, check #1 later.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic ec, input string tag);
    bit was_full;
    bit was_empty;
    @(negedge clk);
    write   = w;
    read    = r;
    data_in = d;
    err_clr = ec;
    @(posedge clk);
    was_full  = (q_m.size() == DEPTH);
    was_empty = (q_m.size() == 0);
    if (r && !was_empty) begin
      exp_dout_m  = q_m.pop_front();
      exp_valid_m = 1'b1;
    end else begin
      exp_valid_m = 1'b0;
    end
    if (w && (!was_full || r)) q_m.push_back(d);
    if (w && was_full && !r) exp_ovf_m = 1'b1;
    else if (ec)             exp_ovf_m = 1'b0;
    if (r && was_empty)      exp_udf_m = 1'b1;
    else if (ec)             exp_udf_m = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    write   = 1'b0;
    read    = 1'b0;
    err_clr = 1'b0;
    reset   = 1'b0;
    #1;
    q_m.delete();
    exp_dout_m  = '0;
    exp_valid_m = 1'b0;
    exp_ovf_m   = 1'b0;
    exp_udf_m   = 1'b0;
    check_all({tag, "_async"});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all({tag, "_rel"});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    write    = 1'b0;
    read     = 1'b0;
    data_in  = 8'h00;
    err_clr  = 1'b0;
    almost_full_thr  = 4'd7;
    almost_empty_thr = 4'd1;
    q_m.delete();
    exp_dout_m  = 8'h00;
    exp_valid_m = 1'b0;
    exp_ovf_m   = 1'b0;
    exp_udf_m   = 1'b0;

    // Reset held then released
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");
    apply_reset("rst");

    // Fill 0x01..0x08, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0, "fill");
    check_val("fill_full", 32'(full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, "drain");
      check_val("drain_order", 32'(data_out), 32'(i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, "drain_idle");
    check_val("drain_empty", 32'(empty), 32'd1);

    // Overflow while full, then clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, "refill");
    step(1'b1, 1'b0, 8'hAA, 1'b0, "ovf");
    check_val("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, "ovf_clr");
    check_val("ovf_clr", 32'(overflow), 32'd0);

    // Read+write at full: count holds, 0x55 queued at the tail
    step(1'b1, 1'b1, 8'h55, 1'b0, "full_rw");
    check_val("full_rw_data", 32'(data_out), 32'h10);
    check_val("full_rw_cnt", 32'(fifo_count), 32'd8);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "rw_drain");
    check_val("rw_last", 32'(data_out), 32'h55);

    // Read+write at empty: write only, underflow set
    step(1'b1, 1'b1, 8'h3C, 1'b0, "empty_rw");
    check_val("empty_rw_udf", 32'(underflow), 32'd1);
    check_val("empty_rw_cnt", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0, "empty_rw_pop");
    check_val("empty_rw_data", 32'(data_out), 32'h3C);
    step(1'b0, 1'b1, 8'h00, 1'b1, "udf_and_clr");
    check_val("set_wins", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, "udf_clr");

    // Thresholds 6/1 and wrap with push/pop pairs
    almost_full_thr  = 4'd6;
    almost_empty_thr = 4'd1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, "thr_push");
    check_val("af_at6", 32'(almost_full), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "thr_pop");
    check_val("ae_at1", 32'(almost_empty), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, "wrap_pair");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, "pre_rst");
    apply_reset("mid_rst");
    check_val("mid_rst_cnt", 32'(fifo_count), 32'd0);

    // Randomized phases with varying write/read bias
    for (int ph = 0; ph < 12; ph++) begin
      int wp;
      int rp;
      wp = int'($urandom_range(90, 10));
      rp = int'($urandom_range(90, 10));
      almost_full_thr  = 4'($urandom_range(15, 0));
      almost_empty_thr = 4'($urandom_range(15, 0));
      for (int c = 0; c < 150; c++) begin
        step(($urandom_range(99, 0) < wp), ($urandom_range(99, 0) < rp),
             8'($urandom), ($urandom_range(99, 0) < 5), "rand");
      end
      if (ph == 6) apply_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
